// File: rtl/async_fifo_wr_ctrl.sv
// async_fifo_wr_ctrl: write-side pointer, full/almost-full and fill-level controller for the async FIFO
// Define FIFO_WR_OVERFLOW_EN to add the sticky o_overflow flag for writes attempted while full.
module async_fifo_wr_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LEVEL    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH:0]   iv_rd_gray,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] ov_ram_waddr,
  output logic [ADDR_WIDTH:0]   ov_wr_gray,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic [ADDR_WIDTH:0]   ov_wr_count
`ifdef FIFO_WR_OVERFLOW_EN
  ,
  output logic                  o_overflow
`endif
);
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [PW-1:0] wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d, count_q, count_d, free_d;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] sync_d [SYNC_STAGES];
  logic [PW-1:0] rd_gray_s, rd_bin_s;
  logic          full_q, full_d, af_q, af_d, accept;
  // accept is gated by reset_n so no RAM write can slip out while reset is held
  always_comb begin
    accept    = i_wr_en & ~full_q & reset_n;
    wr_bin_d  = wr_bin_q + PW'(accept);
    wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
    sync_d[0] = iv_rd_gray;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    rd_gray_s = sync_q[SYNC_STAGES-1];
    rd_bin_s  = '0;
    for (int i = 0; i < PW; i++) rd_bin_s[i] = ^(rd_gray_s >> i);
    full_d    = wr_gray_d == {~rd_gray_s[PW-1:PW-2], rd_gray_s[PW-3:0]};
    count_d   = wr_bin_d - rd_bin_s;
    free_d    = PW'(DEPTH) - count_d;
    af_d      = free_d <= PW'(AF_LEVEL);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      af_q      <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      count_q   <= count_d;
      full_q    <= full_d;
      af_q      <= af_d;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end
  assign o_ram_we      = accept;
  assign ov_ram_waddr  = wr_bin_q[ADDR_WIDTH-1:0];
  assign ov_wr_gray    = wr_gray_q;
  assign o_full        = full_q;
  assign o_almost_full = af_q;
  assign ov_wr_count   = count_q;
`ifdef FIFO_WR_OVERFLOW_EN
  logic ovf_q, ovf_d;
  always_comb ovf_d = ovf_q | (i_wr_en & full_q);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign o_overflow = ovf_q;
`endif
endmodule
